sdram_aref: RTL and testbench

//  Periodic auto-refresh generator for the SDRAM controller; sits beside sdram_init

---
 rtl/sdram_aref.sv | 116 +++++++++++
 tb/tb_sdram_aref.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref.sv
// sdram_aref: periodic auto-refresh generator. Times the refresh interval,
// raises aref_req toward the arbiter, and once granted issues one
// PRECHARGE-ALL followed by AREF_TIMES AUTO-REFRESH commands with tRP/tRFC
// NOP spacing, then pulses aref_end to hand the bus back.
module sdram_aref #(
    parameter int REF_PERIOD = 375,
    parameter int TRP_CLK    = 2,
    parameter int TRFC_CLK   = 7,
    parameter int AREF_TIMES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic        aref_end,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [11:0] aref_addr
);

    localparam int TW   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int WMAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
    localparam int CW   = $clog2(WMAX + 1);
    localparam int AW   = $clog2(AREF_TIMES + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCHA = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE, S_PCHA, S_TRP, S_AREF, S_TRFC, S_END
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   cnt_clk;
    logic [AW-1:0]   cnt_aref;
    logic            expire;
    logic            accept;
    logic [3:0]      cmd_nxt;

    assign expire = init_end && (timer == TW'(REF_PERIOD - 1));
    assign accept = (state == S_IDLE) && aref_req && aref_en;

    // Refresh interval timer; free-runs (even mid-sequence) once init is done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     timer <= '0;
        else if (!init_end) timer <= '0;
        else if (expire)    timer <= '0;
        else                timer <= timer + 1'b1;
    end

    // Sticky request: expiry sets it and beats a same-edge accept.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     aref_req <= 1'b0;
        else if (!init_end) aref_req <= 1'b0;
        else if (expire)    aref_req <= 1'b1;
        else if (accept)    aref_req <= 1'b0;
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next state and the command that goes with it.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = CMD_NOP;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PCHA;
            S_PCHA: state_nxt = S_TRP;
            S_TRP:  if (cnt_clk == CW'(TRP_CLK - 1)) state_nxt = S_AREF;
            S_AREF: state_nxt = S_TRFC;
            S_TRFC: if (cnt_clk == CW'(TRFC_CLK - 1))
                        state_nxt = (cnt_aref < AW'(AREF_TIMES)) ? S_AREF : S_END;
            S_END:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt == S_PCHA)      cmd_nxt = CMD_PCHA;
        else if (state_nxt == S_AREF) cmd_nxt = CMD_AREF;
    end

    // Wait-cycle counter for TRP/TRFC and count of AUTO-REFRESHes issued.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_clk  <= '0;
            cnt_aref <= '0;
        end else begin
            if ((state == S_TRP || state == S_TRFC) && state_nxt == state)
                cnt_clk <= cnt_clk + 1'b1;
            else
                cnt_clk <= '0;
            if (state == S_AREF)     cnt_aref <= cnt_aref + 1'b1;
            else if (state == S_END) cnt_aref <= '0;
        end
    end

    // Registered outputs, aligned with the state they belong to.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            aref_cmd  <= CMD_NOP;
            aref_end  <= 1'b0;
            aref_ba   <= 2'b11;
            aref_addr <= 12'hFFF;
        end else begin
            aref_cmd  <= cmd_nxt;
            aref_end  <= (state_nxt == S_END);
            aref_ba   <= 2'b11;
            aref_addr <= 12'hFFF;
        end
    end

endmodule

// File: tb/tb_sdram_aref.sv
// tb_sdram_aref: directed bench with a reference model that predicts the
// request line and pushes expected command events into a scoreboard queue
// whenever a grant is accepted; DUT outputs are popped and compared.
module tb_sdram_aref;

    localparam int REF_PERIOD = 375;
    localparam int TRP_CLK    = 2;
    localparam int TRFC_CLK   = 7;
    localparam int AREF_TIMES = 2;
    localparam int LAT        = 2 + TRP_CLK + AREF_TIMES * (1 + TRFC_CLK);

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PCHA = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic       endp;
    } ev_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        init_end;
    logic        aref_en;
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [11:0] aref_addr;

    sdram_aref #(
        .REF_PERIOD(REF_PERIOD), .TRP_CLK(TRP_CLK),
        .TRFC_CLK(TRFC_CLK), .AREF_TIMES(AREF_TIMES)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .init_end (init_end),
        .aref_en  (aref_en),
        .aref_req (aref_req),
        .aref_end (aref_end),
        .aref_cmd (aref_cmd),
        .aref_ba  (aref_ba),
        .aref_addr(aref_addr)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  mt = 0;
    int  mleft = 0;
    bit  mreq = 1'b0;
    int  n_seq = 0;
    int  n_end_obs = 0;
    int  n_aref_obs = 0;
    int  run = 0;
    int  max_run = 0;
    ev_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model evaluated at each rising edge with the inputs in force.
    task automatic model_edge();
        bit acc, exp_t;
        acc   = (mleft == 0) && mreq && aref_en;
        exp_t = init_end && (mt == REF_PERIOD - 1);
        mt    = (!init_end || exp_t) ? 0 : mt + 1;
        if (!init_end)  mreq = 1'b0;
        else if (exp_t) mreq = 1'b1;
        else if (acc)   mreq = 1'b0;
        if (acc) begin
            mleft = LAT;
            n_seq++;
            q.push_back('{cyc, PCHA, 1'b0});
            for (int k = 0; k < AREF_TIMES; k++)
                q.push_back('{cyc + 1 + TRP_CLK + k * (1 + TRFC_CLK), AREF, 1'b0});
            q.push_back('{cyc + LAT - 1, NOP, 1'b1});
        end else if (mleft > 0) begin
            mleft--;
        end
    endtask

    task automatic monitor();
        ev_t e;
        chk("aref_req", {31'd0, aref_req}, {31'd0, mreq});
        chk("ba_addr", {18'd0, aref_ba, aref_addr}, 32'h3FFF);
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("aref_cmd", {28'd0, aref_cmd}, {28'd0, e.cmd});
            chk("aref_end", {31'd0, aref_end}, {31'd0, e.endp});
        end else if (aref_cmd !== NOP || aref_end !== 1'b0) begin
            chk("unexpected_event", {27'd0, aref_end, aref_cmd}, {27'd0, 1'b0, NOP});
        end
        if (aref_end === 1'b1)   n_end_obs++;
        if (aref_cmd === AREF)   n_aref_obs++;
        if (aref_req === 1'b1) run++; else run = 0;
        if (run > max_run) max_run = run;
    endtask

    task automatic step();
        @(posedge sys_clk);
        cyc++;
        model_edge();
        #1;
        monitor();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, aref_req}, 32'd0);
        chk({tag, "_end"}, {31'd0, aref_end}, 32'd0);
        chk({tag, "_cmd"}, {28'd0, aref_cmd}, {28'd0, NOP});
        chk({tag, "_ba_addr"}, {18'd0, aref_ba, aref_addr}, 32'h3FFF);
    endtask

    initial begin
        int c0, rise, bad;
        bit found;
        sys_rst_n = 1'b0;
        init_end  = 1'b0;
        aref_en   = 1'b0;
        #50;
        check_reset_outputs("por");
        #50;
        sys_rst_n = 1'b1;

        // 1: no refresh activity while init is not done, even with grant high
        aref_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (aref_req !== 1'b0 || aref_cmd !== NOP) bad++;
        end
        chk("t1_idle_cycles_bad", bad, 0);
        aref_en = 1'b0;

        // 2: request rises exactly REF_PERIOD cycles after init_end, then sticks
        init_end = 1'b1;
        c0 = cyc;
        rise = -1;
        for (int i = 0; i < REF_PERIOD + 5; i++) begin
            step();
            if (aref_req === 1'b1 && rise < 0) rise = cyc - c0;
        end
        chk("t2_req_latency", rise, REF_PERIOD);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (aref_req !== 1'b1) bad++;
        end
        chk("t2_req_sticky_bad", bad, 0);

        // 3: single grant -> one full sequence
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        chk("t3_pcha_on_accept", {28'd0, aref_cmd}, {28'd0, PCHA});
        chk("t3_req_cleared", {31'd0, aref_req}, 32'd0);
        for (int i = 0; i < LAT + 5; i++) step();
        chk("t3_queue_drained", q.size(), 0);

        // 4: grant held permanently
        aref_en    = 1'b1;
        n_seq      = 0;
        n_end_obs  = 0;
        n_aref_obs = 0;
        max_run    = 0;
        for (int i = 0; i < 10000; i++) step();
        chk("t4_end_count", n_end_obs, n_seq);
        chk("t4_aref_count", n_aref_obs, n_seq * AREF_TIMES);
        chk("t4_max_req_run", max_run, 1);
        aref_en = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();

        // 5: accept on the expiry edge, grant held through the sequence
        found = 1'b0;
        for (int i = 0; i < 2 * REF_PERIOD + 10 && !found; i++) begin
            step();
            if (mreq && mt == REF_PERIOD - 1) found = 1'b1;
        end
        chk("t5_align_found", {31'd0, found}, 32'd1);
        aref_en = 1'b1;
        step();
        chk("t5_req_after_accept", {31'd0, aref_req}, 32'd1);
        chk("t5_pcha", {28'd0, aref_cmd}, {28'd0, PCHA});
        for (int i = 0; i < LAT + 2; i++) step();
        aref_en = 1'b0;
        chk("t5_second_seq_pending", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < LAT + 5; i++) step();
        chk("t5_queue_drained", q.size(), 0);

        // 6: reset pulse during TRFC
        found = 1'b0;
        for (int i = 0; i < REF_PERIOD + 10 && !found; i++) begin
            step();
            if (aref_req === 1'b1) found = 1'b1;
        end
        chk("t6_req_seen", {31'd0, found}, 32'd1);
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        mt = 0; mreq = 1'b0; mleft = 0;
        q.delete();
        #2;
        sys_rst_n = 1'b1;
        c0 = cyc;
        rise = -1;
        for (int i = 0; i < REF_PERIOD + 10 && rise < 0; i++) begin
            step();
            if (aref_req === 1'b1) rise = cyc - c0;
        end
        chk("t6_req_latency", rise, REF_PERIOD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
